jpeg_bayt_paketleyici: RTL

- Sits directly upstream of huffman_decoder.
- Accepts the raw JPEG entropy-coded segment one byte at a time.
- Removes 0xFF00 byte stuffing, discards 0xFF fill bytes, detects markers, and packs bytes MSB-first into WB_BIT-wide words on the decoder's m_veri/m_gecerli/m_hazir interface.
- On a marker it pads and flushes the final word, reports the marker code, then halts until software clears it.

---
 rtl/jpeg_bayt_paketleyici_pkg.sv | 36 +++
 rtl/jpeg_bayt_paketleyici_if.sv | 10 +
 rtl/jpeg_bayt_paketleyici_suzgec.sv | 49 ++++
 rtl/jpeg_bayt_paketleyici.sv | 134 +++++++++++++
 4 files changed

// File: rtl/jpeg_bayt_paketleyici_pkg.sv
// Shared constants, state encodings and helpers for the JPEG byte packer.
package jpeg_bayt_paketleyici_pkg;

   localparam int unsigned WB_BIT = 32;
   localparam int unsigned N      = WB_BIT / 8;
   localparam int unsigned KW     = $clog2(N) + 1;

   localparam logic [7:0] BAYT_FF    = 8'hFF;
   localparam logic [7:0] BAYT_00    = 8'h00;
   localparam logic [7:0] DOLGU_BAYT = 8'hFF;

   localparam logic [1:0] VERI       = 2'd0;
   localparam logic [1:0] FF_GORULDU = 2'd1;
   localparam logic [1:0] BOSALT     = 2'd2;
   localparam logic [1:0] DURDU      = 2'd3;

   // Per-byte result of the stuffing filter handed to the packer.
   typedef struct packed {
      logic [7:0] bayt;
      logic       gecerli;
      logic       isaret;
      logic [7:0] isaret_kodu;
   } suzgec_cikis_t;

   // Shift the k accumulated bytes up to the MSB end, filling the tail with pad bytes.
   function automatic logic [WB_BIT-1:0] dolgu_ekle(input logic [WB_BIT-1:0] acc,
                                                     input logic [KW-1:0]     k);
      logic [WB_BIT-1:0] w;
      w = acc;
      for (int unsigned i = 0; i < N; i++) begin
         if (KW'(i) < (KW'(N) - k)) w = {w[WB_BIT-9:0], DOLGU_BAYT};
      end
      return w;
   endfunction

endpackage

// File: rtl/jpeg_bayt_paketleyici_if.sv
// Word stream towards huffman_decoder: data, valid, last-before-marker, ready.
interface jpeg_bayt_paketleyici_if;
   logic [jpeg_bayt_paketleyici_pkg::WB_BIT-1:0] veri;
   logic                                         gecerli;
   logic                                         son;
   logic                                         hazir;

   modport master (output veri, output gecerli, output son, input hazir);
   modport slave  (input veri, input gecerli, input son, output hazir);
endinterface

// File: rtl/jpeg_bayt_paketleyici_suzgec.sv
// Byte-stuffing filter: removes FF00 stuffing, drops fill FFs, flags markers.
module jpeg_dolgu_suzgec
   import jpeg_bayt_paketleyici_pkg::*;
(
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic [7:0]    bayt,
   input  logic          kabul,
   input  logic          temizle,
   output suzgec_cikis_t cikis_c
);

   logic [1:0] durum, durum_n;

   // State register: VERI or FF_GORULDU (an FF is pending).
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) durum <= VERI;
      else         durum <= durum_n;
   end

   // Classify each accepted byte against the pending-FF state.
   always_comb begin
      durum_n = durum;
      cikis_c = '0;
      if (temizle) begin
         durum_n = VERI;
      end else if (kabul) begin
         if (durum == FF_GORULDU) begin
            if (bayt == BAYT_00) begin
               cikis_c.bayt    = BAYT_FF;
               cikis_c.gecerli = 1'b1;
               durum_n         = VERI;
            end else if (bayt != BAYT_FF) begin
               cikis_c.isaret      = 1'b1;
               cikis_c.isaret_kodu = bayt;
               durum_n             = VERI;
            end
         end else begin
            if (bayt == BAYT_FF) begin
               durum_n = FF_GORULDU;
            end else begin
               cikis_c.bayt    = bayt;
               cikis_c.gecerli = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/jpeg_bayt_paketleyici.sv
// Packs filtered JPEG entropy bytes MSB-first into words; pads and halts on a marker.
module jpeg_bayt_paketleyici
   import jpeg_bayt_paketleyici_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [7:0]               s_bayt_i,
   input  logic                     s_gecerli_i,
   output logic                     s_hazir_o,
   jpeg_bayt_paketleyici_if.master  m_if,
   output logic [7:0]               isaret_o,
   output logic                     isaret_gecerli_o,
   input  logic                     temizle_i
);

   // Top state only uses VERI (filter active), BOSALT and DURDU; FF tracking lives in the filter.
   logic [1:0]        durum, durum_n;
   logic              calisir;
   logic [WB_BIT-1:0] acc, acc_n;
   logic [KW-1:0]     k, k_n;
   logic [WB_BIT-1:0] veri_q, veri_n;
   logic              gecerli_q, gecerli_n;
   logic              son_q, son_n;
   logic [7:0]        isaret_q, isaret_n;
   logic              ig_q, ig_n;

   logic              cikis_bos;
   logic              yer_var;
   logic              kabul;
   suzgec_cikis_t     suz;

   // Output register can take a word this cycle.
   assign cikis_bos = !gecerli_q || m_if.hazir;
   // A byte that cannot complete a word never needs the output register.
   assign yer_var   = cikis_bos || (k != KW'(N - 1));
   assign s_hazir_o = calisir && (durum == VERI) && yer_var;
   assign kabul     = s_gecerli_i && s_hazir_o;

   assign m_if.veri        = veri_q;
   assign m_if.gecerli     = gecerli_q;
   assign m_if.son         = son_q;
   assign isaret_o         = isaret_q;
   assign isaret_gecerli_o = ig_q;

   jpeg_dolgu_suzgec u_suzgec (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .bayt    (s_bayt_i),
      .kabul   (kabul),
      .temizle (temizle_i),
      .cikis_c (suz)
   );

   // All state and output registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum     <= VERI;
         calisir   <= 1'b0;
         acc       <= '0;
         k         <= '0;
         veri_q    <= '0;
         gecerli_q <= 1'b0;
         son_q     <= 1'b0;
         isaret_q  <= '0;
         ig_q      <= 1'b0;
      end else begin
         durum     <= durum_n;
         calisir   <= 1'b1;
         acc       <= acc_n;
         k         <= k_n;
         veri_q    <= veri_n;
         gecerli_q <= gecerli_n;
         son_q     <= son_n;
         isaret_q  <= isaret_n;
         ig_q      <= ig_n;
      end
   end

   // Next-state: accumulate, complete words, flush on marker, halt until cleared.
   always_comb begin
      durum_n   = durum;
      acc_n     = acc;
      k_n       = k;
      veri_n    = veri_q;
      gecerli_n = gecerli_q;
      son_n     = son_q;
      isaret_n  = isaret_q;
      ig_n      = ig_q;

      if (gecerli_q && m_if.hazir) gecerli_n = 1'b0;

      case (durum)
         BOSALT: begin
            if (temizle_i) begin
               k_n     = '0;
               durum_n = VERI;
            end else if (cikis_bos) begin
               veri_n    = dolgu_ekle(acc, k);
               gecerli_n = 1'b1;
               son_n     = 1'b1;
               k_n       = '0;
               ig_n      = 1'b1;
               durum_n   = DURDU;
            end
         end
         DURDU: begin
            if (temizle_i) begin
               k_n     = '0;
               ig_n    = 1'b0;
               durum_n = VERI;
            end
         end
         default: begin
            if (temizle_i) begin
               k_n = '0;
            end else if (suz.gecerli) begin
               acc_n = {acc[WB_BIT-9:0], suz.bayt};
               if (k == KW'(N - 1)) begin
                  veri_n    = acc_n;
                  gecerli_n = 1'b1;
                  son_n     = 1'b0;
                  k_n       = '0;
               end else begin
                  k_n = k + KW'(1);
               end
            end else if (suz.isaret) begin
               isaret_n = suz.isaret_kodu;
               durum_n  = BOSALT;
            end
         end
      endcase
   end

endmodule
